// File: rtl/fully_connected.sv
// fully_connected: dense layer computing layer_out[o] = bias[o] + sum_k weight[o][k]*inputs[k], one neuron at a time, with weights/biases read from 1-cycle-latency RAMs (w_read_*, b_read_*), a start/done handshake, and optional ReLU on stored results under FC_RELU_EN
module fully_connected #(
  parameter int INPUT_SIZE = 3,
  parameter int OUTPUT_SIZE = 2,
  parameter int WEIGHTS_WIDTH = 8,
  parameter int BIAS_WIDTH = 32,
  localparam int AW = $clog2(INPUT_SIZE * OUTPUT_SIZE),
  localparam int BW = $clog2(OUTPUT_SIZE),
  localparam int KW = $clog2(INPUT_SIZE + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            done,
  input  logic signed [WEIGHTS_WIDTH-1:0] inputs [INPUT_SIZE],
  output logic                            w_read_en,
  output logic        [AW-1:0]            w_read_addr,
  input  logic signed [WEIGHTS_WIDTH-1:0] w_read_data,
  output logic                            b_read_en,
  output logic        [BW-1:0]            b_read_addr,
  input  logic signed [BIAS_WIDTH-1:0]    b_read_data,
  output logic signed [BIAS_WIDTH-1:0]    layer_out [OUTPUT_SIZE]
);
  typedef enum logic [1:0] {IDLE, BIAS, MAC, DONE} state_t;
  state_t state;
  logic signed [WEIGHTS_WIDTH-1:0] in_reg [INPUT_SIZE];
  logic [KW-1:0] k;
  logic [BW-1:0] o;
  logic signed [BIAS_WIDTH-1:0] acc, sum, res;
  logic signed [2*WEIGHTS_WIDTH-1:0] prod;
  assign prod = w_read_data * in_reg[k - KW'(1)];
  assign sum = acc + BIAS_WIDTH'(prod);
`ifdef FC_RELU_EN
  assign res = sum[BIAS_WIDTH-1] ? '0 : sum;
`else
  assign res = sum;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      w_read_en <= 1'b0;
      w_read_addr <= '0;
      b_read_en <= 1'b0;
      b_read_addr <= '0;
      acc <= '0;
      k <= '0;
      o <= '0;
      in_reg <= '{default: '0};
      layer_out <= '{default: '0};
    end else begin
      done <= 1'b0;
      w_read_en <= 1'b0;
      w_read_addr <= '0;
      b_read_en <= 1'b0;
      b_read_addr <= '0;
      case (state)
        IDLE: if (start) begin
          in_reg <= inputs;
          o <= '0;
          b_read_en <= 1'b1;
          state <= BIAS;
        end
        BIAS: begin
          k <= '0;
          w_read_en <= 1'b1;
          w_read_addr <= AW'(o * INPUT_SIZE);
          state <= MAC;
        end
        MAC: begin
          acc <= (k == '0) ? b_read_data : sum;
          if (k < KW'(INPUT_SIZE - 1)) begin
            w_read_en <= 1'b1;
            w_read_addr <= AW'(o * INPUT_SIZE + k + 1);
          end
          if (k == KW'(INPUT_SIZE)) begin
            layer_out[o] <= res;
            if (o == BW'(OUTPUT_SIZE - 1)) begin
              done <= 1'b1;
              state <= DONE;
            end else begin
              o <= o + 1'b1;
              b_read_en <= 1'b1;
              b_read_addr <= o + 1'b1;
              state <= BIAS;
            end
          end else k <= k + 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fully_connected.sv
// tb_fully_connected: randomized self-checking bench for fully_connected against a dot-product reference model
module tb_fully_connected;
  localparam int IS = 3, OS = 2, P = IS + 2;
  logic clk = 0, rst = 1, start = 0;
  logic done, w_read_en, b_read_en;
  logic [2:0] w_read_addr;
  logic [0:0] b_read_addr;
  logic signed [7:0] in_v [IS];
  logic signed [7:0] w_read_data;
  logic signed [31:0] b_read_data;
  logic signed [31:0] layer_out [OS];
  logic signed [7:0] wmem [IS*OS];
  logic signed [31:0] bmem [OS];
  int exp_out [OS];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  fully_connected dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .inputs(in_v),
    .w_read_en(w_read_en), .w_read_addr(w_read_addr), .w_read_data(w_read_data),
    .b_read_en(b_read_en), .b_read_addr(b_read_addr), .b_read_data(b_read_data),
    .layer_out(layer_out)
  );
  always @(posedge clk) begin
    if (w_read_en) w_read_data <= wmem[w_read_addr];
    if (b_read_en) b_read_data <= bmem[b_read_addr];
  end
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int sig(int d, int be, int ba, int we, int wa);
    return (d << 12) | (be << 11) | (ba << 8) | (we << 7) | wa;
  endfunction
  task automatic rand_data();
    for (int i = 0; i < IS; i++) in_v[i] = 8'($urandom);
    for (int i = 0; i < IS*OS; i++) wmem[i] = 8'($urandom);
    for (int i = 0; i < OS; i++) bmem[i] = $urandom;
  endtask
  task automatic run(input bit poke, input int rst_edge);
    int exp_new [OS];
    int old [OS];
    int s, j, o, busy, wr;
    old = exp_out;
    for (int n = 0; n < OS; n++) begin
      s = bmem[n];
      for (int i = 0; i < IS; i++) s += int'(wmem[n*IS+i]) * int'(in_v[i]);
`ifdef FC_RELU_EN
      if (s < 0) s = 0;
`endif
      exp_new[n] = s;
    end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    if (poke) for (int i = 0; i < IS; i++) in_v[i] = 8'($urandom);
    for (int c = 0; c <= P*OS + 1; c++) begin
      if (c == rst_edge) begin
        check("rst_bus", sig(done, b_read_en, b_read_addr, w_read_en, w_read_addr), 0);
        for (int i = 0; i < OS; i++) check("rst_out", layer_out[i], 0);
        rst = 0;
        exp_out = '{default: 0};
        return;
      end
      j = c % P;
      o = c / P;
      busy = int'(c < P*OS);
      wr = int'(busy != 0 && j >= 1 && j <= IS);
      check("bus", sig(done, b_read_en, b_read_addr, w_read_en, w_read_addr),
            sig(int'(c == P*OS), int'(busy != 0 && j == 0), (busy != 0 && j == 0) ? o : 0,
                wr, wr != 0 ? o*IS + j - 1 : 0));
      for (int i = 0; i < OS; i++) check("out", layer_out[i], c >= P*(i+1) ? exp_new[i] : old[i]);
      if (poke) start = (c == 2);
      if (c == rst_edge - 1) rst = 1;
      @(posedge clk); #1;
    end
    exp_out = exp_new;
  endtask
  initial begin
    for (int i = 0; i < IS; i++) in_v[i] = 0;
    exp_out = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    check("reset_bus", sig(done, b_read_en, b_read_addr, w_read_en, w_read_addr), 0);
    for (int i = 0; i < OS; i++) check("reset_out", layer_out[i], 0);
    start = 1;
    @(posedge clk); #1;
    rst = 0;
    start = 0;
    check("rst_start_bus", sig(done, b_read_en, b_read_addr, w_read_en, w_read_addr), 0);
    @(posedge clk); #1;
    check("start_ignored", sig(done, b_read_en, b_read_addr, w_read_en, w_read_addr), 0);
    in_v = '{8'sd1, 8'sd2, 8'sd3};
    wmem = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6};
    bmem = '{32'sd10, 32'sd20};
    run(0, -1);
    check("basic_o0", layer_out[0], 24);
    check("basic_o1", layer_out[1], 52);
    in_v = '{default: -8'sd128};
    wmem = '{-8'sd128, -8'sd128, -8'sd128, 8'sd127, 8'sd127, 8'sd127};
    bmem = '{-32'sd1, 32'sd0};
    run(0, -1);
    check("ext_o0", layer_out[0], 49151);
`ifdef FC_RELU_EN
    check("ext_o1", layer_out[1], 0);
`else
    check("ext_o1", layer_out[1], -48768);
`endif
    in_v = '{8'sd1, 8'sd0, 8'sd0};
    wmem = '{8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    bmem = '{32'sh7FFFFFFF, 32'sd0};
`ifdef FC_RELU_EN
    run(0, -1);
    check("wrap_o0", layer_out[0], 0);
`else
    run(0, -1);
    check("wrap_o0", layer_out[0], -64'sd2147483648);
`endif
    rand_data();
    run(1, -1);
    rand_data();
    run(0, 5);
    rand_data();
    run(0, -1);
    for (int r = 0; r < 6; r++) begin
      rand_data();
      run(r % 2 == 1, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
